// File: rtl/conv_wreg_loader_pkg.sv
// Shared defaults, state encoding and counter helpers for the convolution
// weight-register loader.
package conv_wreg_loader_pkg;

  localparam int unsigned AWIDTH_DEF  = 12;
  localparam int unsigned NWEIGHT_DEF = 25;
  localparam int unsigned RDLAT_DEF   = 1;
  localparam int unsigned CNT_W       = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // True when cnt is the index of the final word of an n-word load.
  function automatic logic is_last(input logic [CNT_W-1:0] cnt, input int unsigned n);
    return cnt == CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/conv_wreg_loader_rd_valid_pipe.sv
// DEPTH-stage delay line that turns an issued-read strobe into a
// read-data-valid strobe for a fixed-latency memory.
module conv_wreg_loader_rd_valid_pipe #(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic valid_i,
  output logic valid_o
);

  logic [DEPTH-1:0] stage_q;
  logic [DEPTH-1:0] stage_d;

  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = valid_i;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign valid_o = stage_q[DEPTH-1];

endmodule

// File: rtl/conv_wreg_loader.sv
// Fetches NWEIGHT consecutive words from weight memory through the arbiter
// and strobes each returned word into the shift-style weight register.
module conv_wreg_loader
  import conv_wreg_loader_pkg::*;
#(
  parameter int unsigned AWIDTH  = AWIDTH_DEF,
  parameter int unsigned NWEIGHT = NWEIGHT_DEF,
  parameter int unsigned RDLAT   = RDLAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AWIDTH-1:0] base_addr,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [AWIDTH-1:0] mem_addr,
  output logic              wreg_we,
  output logic              busy,
  output logic              done
);

  state_e             state_q, state_d;
  logic [AWIDTH-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]   issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]   recv_cnt_q, recv_cnt_d;
  logic               mem_req_q, mem_req_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               wreg_we_q;
  logic               grant_c;

  assign grant_c = mem_req_q & mem_gnt;

  conv_wreg_loader_rd_valid_pipe #(
    .DEPTH (RDLAT)
  ) u_rd_valid_pipe (
    .clk     (clk),
    .rst     (rst),
    .valid_i (grant_c),
    .valid_o (wreg_we_q)
  );

  // Next-state: request stays up and address holds until granted.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    mem_req_d   = mem_req_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    if (wreg_we_q) begin
      recv_cnt_d = recv_cnt_q + CNT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d      = base_addr;
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
          mem_req_d   = 1'b1;
          busy_d      = 1'b1;
          state_d     = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (grant_c) begin
          addr_d      = addr_q + AWIDTH'(1);
          issue_cnt_d = issue_cnt_q + CNT_W'(1);
          if (is_last(issue_cnt_q, NWEIGHT)) begin
            mem_req_d = 1'b0;
            state_d   = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (wreg_we_q && is_last(recv_cnt_q, NWEIGHT)) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      mem_req_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      mem_req_q   <= mem_req_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = addr_q;
  assign wreg_we  = wreg_we_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_conv_wreg_loader.sv
// Bench for conv_wreg_loader: two instances (read latency 1 and 3) share the
// stimulus; a transaction-level model predicts every output each cycle.
module tb_conv_wreg_loader;

  localparam int NW = 25;
  localparam int NV = 9;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mem_gnt;
  logic [11:0] base_addr;

  logic        req1, we1, busy1, done1;
  logic [11:0] addr1;
  logic        req3, we3, busy3, done3;
  logic [11:0] addr3;

  conv_wreg_loader #(.AWIDTH(12), .NWEIGHT(25), .RDLAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .mem_req(req1), .mem_gnt(mem_gnt), .mem_addr(addr1),
    .wreg_we(we1), .busy(busy1), .done(done1)
  );

  conv_wreg_loader #(.AWIDTH(12), .NWEIGHT(25), .RDLAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .mem_req(req3), .mem_gnt(mem_gnt), .mem_addr(addr3),
    .wreg_we(we3), .busy(busy3), .done(done3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] base;
    int mode;       // 0: grant tied high, 1: grant 1,0,1,0.., 2: random grant
    int p1, p2;     // extra start pulses at these cycle offsets (-1 = none)
    int cyc1, cyc3; // start-to-done cycles per instance (-1 = not checked)
    int pul1, pul3;
    int dn1, dn3;
  } vec_t;

  vec_t tbl [NV];

  int nvec, nmis, ncyc;

  // Model state per instance: 0 idle, 1 loading, 2 done cycle.
  int          st     [2];
  logic [11:0] mbase  [2];
  int          issued [2];
  int          recv   [2];
  bit          ghist  [2][8];
  logic [11:0] ahist  [2][8];
  logic [15:0] w      [2][NW];
  int          pulses [2];
  int          dones  [2];
  int          tdone  [2];

  function automatic logic [15:0] mem_rd(input logic [11:0] a);
    return {4'h0, a};
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s inst%0d cyc %0d: got %0h expected %0h", name, k, ncyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      st[k] = 0;
      issued[k] = 0;
      recv[k] = 0;
      for (int s = 0; s < 8; s++) ghist[k][s] = 1'b0;
    end
  endtask

  task automatic mon(input int k, input int lat, input logic req, input logic [11:0] addr,
                     input logic we, input logic bsy, input logic dn);
    int slot;
    bit exp_we, exp_req, g;
    logic [11:0] ea;
    logic [15:0] din;
    slot   = (ncyc + 8 - lat) % 8;
    exp_we = ghist[k][slot];
    chk("wreg_we", k, 32'(we), 32'(exp_we));
    if (we) begin
      din = exp_we ? mem_rd(ahist[k][slot]) : 16'hDEAD;
      for (int i = 0; i < NW - 1; i++) w[k][i] = w[k][i+1];
      w[k][NW-1] = din;
      pulses[k]++;
    end
    if (exp_we) recv[k]++;
    chk("busy", k, 32'(bsy), 32'(st[k] == 1));
    chk("done", k, 32'(dn), 32'(st[k] == 2));
    if (dn) begin
      dones[k]++;
      if (tdone[k] < 0) tdone[k] = ncyc;
    end
    if (st[k] == 2) begin
      for (int i = 0; i < NW; i++)
        chk($sformatf("weight%0d", i), k, 32'(w[k][i]), 32'(mem_rd(mbase[k] + 12'(i))));
    end
    exp_req = (st[k] == 1) && (issued[k] < NW);
    chk("mem_req", k, 32'(req), 32'(exp_req));
    ea = mbase[k] + 12'(issued[k]);
    if (exp_req) chk("mem_addr", k, 32'(addr), 32'(ea));
    g = exp_req && mem_gnt;
    ghist[k][ncyc % 8] = g;
    ahist[k][ncyc % 8] = ea;
    if (g) issued[k]++;
    case (st[k])
      2: st[k] = 0;
      1: if (recv[k] == NW) st[k] = 2;
      default: begin
        if (start) begin
          st[k] = 1;
          mbase[k] = base_addr;
          issued[k] = 0;
          recv[k] = 0;
        end
      end
    endcase
  endtask

  always @(negedge clk) begin
    if (rst) begin
      model_reset();
    end else begin
      mon(0, 1, req1, addr1, we1, busy1, done1);
      mon(1, 3, req3, addr3, we3, busy3, done3);
    end
    ncyc++;
  end

  function automatic logic gnt_val(input int mode, input int i);
    if (mode == 0) return 1'b1;
    if (mode == 1) return 1'((i % 2) == 1);
    return 1'($urandom_range(0, 3) != 0);
  endfunction

  task automatic chk_zero();
    chk("rst_mem_req", 0, 32'(req1), 32'h0);
    chk("rst_wreg_we", 0, 32'(we1), 32'h0);
    chk("rst_busy", 0, 32'(busy1), 32'h0);
    chk("rst_done", 0, 32'(done1), 32'h0);
    chk("rst_mem_addr", 0, 32'(addr1), 32'h0);
    chk("rst_mem_req", 1, 32'(req3), 32'h0);
    chk("rst_wreg_we", 1, 32'(we3), 32'h0);
    chk("rst_busy", 1, 32'(busy3), 32'h0);
    chk("rst_done", 1, 32'(done3), 32'h0);
    chk("rst_mem_addr", 1, 32'(addr3), 32'h0);
  endtask

  task automatic run_vec(input vec_t v);
    int s;
    bit fin;
    @(posedge clk); #1;
    s = ncyc;
    for (int k = 0; k < 2; k++) begin
      pulses[k] = 0;
      dones[k] = 0;
      tdone[k] = -1;
    end
    start = 1'b1;
    base_addr = v.base;
    mem_gnt = gnt_val(v.mode, 0);
    fin = 1'b0;
    for (int i = 1; i < 400; i++) begin
      @(posedge clk); #1;
      start = 1'(i == v.p1 || i == v.p2);
      mem_gnt = gnt_val(v.mode, i);
      if (i > v.p1 && i > v.p2 && !start && st[0] == 0 && st[1] == 0) begin
        fin = 1'b1;
        break;
      end
    end
    start = 1'b0;
    if (!fin) begin
      nvec++;
      nmis++;
      $display("FAIL load_timeout base %0h: got no completion expected completion within 400 cycles", v.base);
    end
    chk("pulse_count", 0, 32'(pulses[0]), 32'(v.pul1));
    chk("pulse_count", 1, 32'(pulses[1]), 32'(v.pul3));
    chk("done_count", 0, 32'(dones[0]), 32'(v.dn1));
    chk("done_count", 1, 32'(dones[1]), 32'(v.dn3));
    if (v.cyc1 >= 0) chk("load_cycles", 0, 32'(tdone[0] - s), 32'(v.cyc1));
    if (v.cyc3 >= 0) chk("load_cycles", 1, 32'(tdone[1] - s), 32'(v.cyc3));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no end of test expected end before 400000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv;
    nvec = 0;
    nmis = 0;
    ncyc = 0;
    rst = 1'b1;
    start = 1'b0;
    mem_gnt = 1'b0;
    base_addr = '0;
    model_reset();

    tbl[0] = '{12'h100, 0, -1, -1, 27, 29, 25, 25, 1, 1};
    tbl[1] = '{12'h200, 1, -1, -1, 51, 53, 25, 25, 1, 1};
    tbl[2] = '{12'h300, 0,  5, 27, 27, 29, 25, 25, 1, 1};
    tbl[3] = '{12'h400, 0, 28, -1, 27, 29, 50, 25, 2, 1};
    tbl[4] = '{12'hFF0, 0, -1, -1, 27, 29, 25, 25, 1, 1};
    tbl[5] = '{12'hFFA, 2, -1, -1, -1, -1, 25, 25, 1, 1};
    tbl[6] = '{12'($urandom), 2, -1, -1, -1, -1, 25, 25, 1, 1};
    tbl[7] = '{12'($urandom), 2, -1, -1, -1, -1, 25, 25, 1, 1};
    tbl[8] = '{12'($urandom), 1, -1, -1, 51, 53, 25, 25, 1, 1};

    @(posedge clk); #1;
    chk_zero();
    @(posedge clk); #1;
    rst = 1'b0;

    for (int t = 0; t < NV; t++) run_vec(tbl[t]);

    // Abort after 10 grants, then confirm the block stays quiet until restarted.
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = 12'h500;
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_zero();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    rv = '{12'h5A0, 0, -1, -1, 27, 29, 25, 25, 1, 1};
    run_vec(rv);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/conv_wreg_loader.md
Name: conv_wreg_loader

Overview:
Sequencer that fills the 25-entry shift-style convolution weight register from the shared weight memory. On a start pulse it issues NWEIGHT sequential read requests from a base address through a request/grant port into the memory arbiter. It tracks the fixed read latency and raises the weight register write-enable exactly once per returned word, so weight0 holds mem[base] and weight24 holds mem[base+24] when done fires. It sits between the layer controller (start/done) and the weight register plus memory arbiter.

Parameters:
AWIDTH, 12, weight memory address width
NWEIGHT, 25, words per load (kernel taps); 1..31
RDLAT, 1, memory read latency in cycles from granted request to valid read_data; 1..4

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
start  in  1  single-cycle load request; sampled only in IDLE
base_addr  in  AWIDTH  first weight address, captured on accepted start
mem_req  out  1  read request to arbiter
mem_gnt  in  1  arbiter grant; a read is issued in the cycle mem_req && mem_gnt
mem_addr  out  AWIDTH  read address, valid while mem_req
wreg_we  out  1  shift enable to the weight register, aligned with valid read_data
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse when the last word has been shifted in

Behaviour:
- Reset (async, rst=1): state IDLE; mem_req=0, mem_addr=0, wreg_we=0, busy=0, done=0; counters and valid pipe cleared. Weight register contents are not touched (it has no reset).
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE: start=1 -> capture base_addr into addr register, issue_cnt=0, recv_cnt=0, go FETCH; busy=1 from next cycle.
- FETCH: mem_req=1, mem_addr=addr register. On mem_gnt: addr+1 (wraps modulo 2^AWIDTH), issue_cnt+1; when the granted read is number NWEIGHT-1, go DRAIN. mem_req drops in the cycle after the last grant. Without grant, mem_req and mem_addr hold stable (no address change while requesting).
- Valid pipe: RDLAT-deep shift register; bit0 is loaded with (mem_req && mem_gnt) each cycle. wreg_we = last stage. A grant in cycle t gives wreg_we=1 in cycle t+RDLAT. Gaps in grant produce matching gaps in wreg_we.
- recv_cnt increments on each wreg_we. DRAIN: wait until recv_cnt reaches NWEIGHT (last wreg_we cycle), then go DONE.
- DONE: done=1 for exactly one cycle, busy=0 in the same cycle, return to IDLE. A start in the DONE cycle is ignored. Earliest restart is the cycle after.
- start while busy: ignored, with no effect on counters.
- Exactly NWEIGHT wreg_we pulses per load, never more. Best case load time = NWEIGHT + RDLAT + 1 cycles from start to done.
- rst mid-load: immediate abort to IDLE, with no further mem_req or wreg_we. The weight register holds a partial shift; the next load overwrites it fully.
- Counters are 5 bits. issue_cnt never exceeds NWEIGHT; no mem_req once issue_cnt==NWEIGHT.

Decomposition:
- Shared package/header (parameters.vh): NWEIGHT, AWIDTH, RDLAT defaults, and state encodings (IDLE=0, FETCH=1, DRAIN=2, DONE=3).
- One natural sub-module: rd_valid_pipe, the RDLAT-deep valid delay line, reusable for other memory clients.

Test Plan:
- Grant tied 1, RDLAT=1, base_addr=0x100, memory word = address value: start -> mem_addr 0x100..0x118 on consecutive cycles; 25 consecutive wreg_we; done 27 cycles after start; weight0=0x100, weight24=0x118.
- Grant toggles 1,0,1,0: mem_addr holds while gnt=0; wreg_we pulses follow grants with 1-cycle delay; total wreg_we=25; done after final pulse; weights are still in order.
- RDLAT=3: the first wreg_we occurs 3 cycles after the first grant; done at start+29 with full grant.
- start pulsed again mid-FETCH and in the DONE cycle: no restart, exactly 25 wreg_we, a single done; a start one cycle after done begins a new load.
- base_addr=0xFF0, AWIDTH=12: addresses wrap 0xFFF -> 0x000 after 16 reads; 25 words total.
- rst asserted after 10 grants: mem_req, wreg_we, busy and done go 0 immediately; after release, nothing happens until start; a new load completes normally with 25 pulses.
